// File: rtl/softmax_norm.sv
// softmax_norm: buffers {exp, sum_exp} pairs and writes q = exp/sum_exp as an 8-bit fraction to the result memory.
// Latency: result write strobe 11 cycles after a push into an idle block; one result per 10 cycles sustained.
// Backpressure: none upstream; in_ready is advisory, pushes into a full FIFO are dropped and flagged on sticky overflow.
// Build option: define SOFTMAX_NORM_ROUND_EN for round-to-nearest (ties up) instead of truncation.
module softmax_norm #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        exp,
    input  logic [7:0]        sum_exp,
    output logic              in_ready,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [7:0]        res_data,
    output logic              row_done,
    output logic              busy,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    // FIFO storage and bookkeeping
    logic [15:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [15:0]       w_head;

    // Divider state
    logic [8:0]        r_rem;
    logic [7:0]        r_div;
    logic [7:0]        r_quot;
    logic [2:0]        r_iter;
    logic              r_sat;

    logic [9:0]        w_r2;
    logic              w_ge;
    logic [8:0]        w_sub;
    logic [7:0]        w_q_final;
    logic [7:0]        w_result;

    // Result addressing
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_elem;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // The FSM only enters LOAD with a non-empty FIFO, so LOAD always pops a valid entry.
    assign w_pop   = (r_state == S_LOAD);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands then.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;
    assign w_head  = r_mem[r_rptr];

    // Shift-and-compare step of the restoring divider; also reused as the rounding test in WRITE.
    assign w_r2  = {r_rem, 1'b0};
    assign w_ge  = (w_r2 >= {2'b00, r_div});
    assign w_sub = w_r2[8:0] - {1'b0, r_div};

`ifdef SOFTMAX_NORM_ROUND_EN
    // Remainder at least half the divisor rounds up; never wrap past 255.
    assign w_q_final = (!r_sat && w_ge && (r_quot != 8'hFF)) ? (r_quot + 8'd1) : r_quot;
`else
    assign w_q_final = r_quot;
`endif

    assign w_result = r_sat ? 8'hFF : w_q_final;

    assign in_ready = !w_full;
    assign busy     = !w_empty || (r_state != S_IDLE);
    assign overflow = r_ovf;
    assign res_addr = r_addr;

    // FIFO payload write; storage needs no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {exp, sum_exp};
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and write-port outputs; outputs stay zero outside WRITE
    always_comb begin
        w_next   = r_state;
        res_wr   = 1'b0;
        res_data = 8'h00;
        row_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_DIV;
            end
            S_DIV: begin
                if (r_iter == 3'd7) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                res_wr   = 1'b1;
                res_data = w_result;
                row_done = (r_elem == 4'd15);
                w_next   = w_empty ? S_IDLE : S_LOAD;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Divider: load operands in LOAD, one quotient bit per DIV cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_iter <= '0;
            r_sat  <= 1'b0;
        end else if (r_state == S_LOAD) begin
            // exp >= sum_exp also catches a zero divisor
            r_sat  <= (w_head[15:8] >= w_head[7:0]);
            r_rem  <= {1'b0, w_head[15:8]};
            r_div  <= w_head[7:0];
            r_quot <= '0;
            r_iter <= '0;
        end else if (r_state == S_DIV) begin
            r_rem  <= w_ge ? w_sub : w_r2[8:0];
            r_quot <= {r_quot[6:0], w_ge};
            r_iter <= r_iter + 3'd1;
        end
    end

    // Result address and per-row element count advance once per write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_elem <= '0;
        end else if (r_state == S_WRITE) begin
            r_addr <= r_addr + 1'b1;
            r_elem <= r_elem + 4'd1;
        end
    end

endmodule
